// File: rtl/room_loader.sv
// room_loader
//   Answers the game-state FSM's INITIALIZATION handshake. When the FSM enters
//   INIT, this block copies the current room's turret/button descriptors from
//   the room ROM into the object RAM. It then zeroes every bullet slot and
//   raises done_init. While the game is in PROGRESSING, it turns the player
//   reaching the exit into a room change or a win, and it owns the room index.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   game_state          FSM state (0000 INIT, 0010 PROGRESSING, ...)
//   exit_reached        level: player is standing on the room exit
//   rom_addr/rom_data   room ROM; data arrives one cycle after the address
//   obj_we/addr/wdata   object RAM write port (slots 0..K-1 = descriptors,
//                       K..T-1 = bullets)
//   done_init           room is fully loaded (held while still in INIT)
//   player_change_room  one-cycle request to move to the next room
//   player_won          sticky: exit reached in the last room
//   room_idx            current room
module room_loader #(
  parameter int NUM_TURRETS = 4,
  parameter int NUM_BUTTONS = 2,
  parameter int NUM_BULLETS = 8,
  parameter int NUM_ROOMS   = 4,
  parameter int ENTRY_W     = 16,
  localparam int K    = NUM_TURRETS + NUM_BUTTONS,
  localparam int T    = K + NUM_BULLETS,
  localparam int RA_W = $clog2(NUM_ROOMS * K),
  localparam int OA_W = $clog2(T),
  localparam int RM_W = $clog2(NUM_ROOMS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         game_state,
  input  logic               exit_reached,
  output logic [RA_W-1:0]    rom_addr,
  input  logic [ENTRY_W-1:0] rom_data,
  output logic               obj_we,
  output logic [OA_W-1:0]    obj_addr,
  output logic [ENTRY_W-1:0] obj_wdata,
  output logic               done_init,
  output logic               player_change_room,
  output logic               player_won,
  output logic [RM_W-1:0]    room_idx
);

  localparam logic [3:0] GS_INIT = 4'b0000;
  localparam logic [3:0] GS_PROG = 4'b0010;
  // Counter must reach NUM_BULLETS+1 in CLEAR (last write plus one settle cycle).
  localparam int CNT_W = OA_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, CLEAR, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RA_W-1:0]      rom_addr_q, rom_addr_d;
  logic                 obj_we_q, obj_we_d;
  logic [OA_W-1:0]      obj_addr_q, obj_addr_d;
  logic [ENTRY_W-1:0]   obj_wdata_q, obj_wdata_d;
  logic                 done_q, done_d;
  logic                 pcr_q, pcr_d;
  logic                 won_q, won_d;
  logic [RM_W-1:0]      room_q, room_d;
  logic                 pending_q, pending_d;
  logic                 exit_prev_q, exit_prev_d;

  logic                 in_init;
  logic                 exit_edge;
  logic [RM_W-1:0]      room_sel;

  assign in_init   = (game_state == GS_INIT);
  assign exit_edge = exit_reached & ~exit_prev_q & (game_state == GS_PROG);
  // Room used for the load: the pending advance is applied on INIT entry.
  assign room_sel  = pending_q ? room_q + RM_W'(1) : room_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rom_addr_d  = rom_addr_q;
    obj_we_d    = 1'b0;
    obj_addr_d  = obj_addr_q;
    obj_wdata_d = obj_wdata_q;
    done_d      = done_q;
    pcr_d       = 1'b0;
    won_d       = won_q;
    room_d      = room_q;
    pending_d   = pending_q;
    exit_prev_d = exit_reached;

    case (state_q)
      IDLE: begin
        if (in_init) begin
          state_d    = LOAD;
          cnt_d      = '0;
          room_d     = room_sel;
          pending_d  = 1'b0;
          rom_addr_d = RA_W'(int'(room_sel) * K);
        end
      end
      LOAD: begin
        if (!in_init) begin
          state_d = IDLE;
        end else begin
          // Data for address j-1 is on rom_data while address j is driven.
          if (cnt_q != '0) begin
            obj_we_d    = 1'b1;
            obj_addr_d  = OA_W'(cnt_q - CNT_W'(1));
            obj_wdata_d = rom_data;
          end
          if (cnt_q == CNT_W'(K - 1)) begin
            state_d = CLEAR;
            cnt_d   = '0;
          end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            rom_addr_d = rom_addr_q + RA_W'(1);
          end
        end
      end
      CLEAR: begin
        if (!in_init) begin
          state_d = IDLE;
        end else begin
          if (cnt_q == '0) begin
            // Trailing ROM descriptor still in flight from LOAD.
            obj_we_d    = 1'b1;
            obj_addr_d  = OA_W'(K - 1);
            obj_wdata_d = rom_data;
          end else if (cnt_q <= CNT_W'(NUM_BULLETS)) begin
            obj_we_d    = 1'b1;
            obj_addr_d  = OA_W'(K - 1) + OA_W'(cnt_q);
            obj_wdata_d = '0;
          end
          // One extra cycle so done_init rises after the last write is visible.
          if (cnt_q == CNT_W'(NUM_BULLETS + 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (!in_init) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Exit edges only count in PROGRESSING, so they never race an INIT entry.
    if (exit_edge) begin
      if (room_q == RM_W'(NUM_ROOMS - 1)) begin
        won_d = 1'b1;
      end else if (!pending_q) begin
        pcr_d     = 1'b1;
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rom_addr_q  <= '0;
      obj_we_q    <= 1'b0;
      obj_addr_q  <= '0;
      obj_wdata_q <= '0;
      done_q      <= 1'b0;
      pcr_q       <= 1'b0;
      won_q       <= 1'b0;
      room_q      <= '0;
      pending_q   <= 1'b0;
      exit_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rom_addr_q  <= rom_addr_d;
      obj_we_q    <= obj_we_d;
      obj_addr_q  <= obj_addr_d;
      obj_wdata_q <= obj_wdata_d;
      done_q      <= done_d;
      pcr_q       <= pcr_d;
      won_q       <= won_d;
      room_q      <= room_d;
      pending_q   <= pending_d;
      exit_prev_q <= exit_prev_d;
    end
  end

  assign rom_addr           = rom_addr_q;
  assign obj_we             = obj_we_q;
  assign obj_addr           = obj_addr_q;
  assign obj_wdata          = obj_wdata_q;
  assign done_init          = done_q;
  assign player_change_room = pcr_q;
  assign player_won         = won_q;
  assign room_idx           = room_q;

endmodule

// File: tb/tb_room_loader.sv
module tb_room_loader;

  localparam int K    = 6;
  localparam int T    = 14;
  localparam int NR   = 4;
  localparam int RA_W = 5;
  localparam int OA_W = 4;
  localparam int RM_W = 2;
  localparam logic [3:0] GS_INIT = 4'b0000;
  localparam logic [3:0] GS_PROG = 4'b0010;
  localparam logic [3:0] GS_OVER = 4'b0100;
  localparam logic [3:0] GS_WIN  = 4'b0101;
  localparam logic [3:0] GS_END  = 4'b0110;

  logic            clk;
  logic            reset;
  logic [3:0]      game_state;
  logic            exit_reached;
  logic [RA_W-1:0] rom_addr;
  logic [15:0]     rom_data;
  logic            obj_we;
  logic [OA_W-1:0] obj_addr;
  logic [15:0]     obj_wdata;
  logic            done_init;
  logic            player_change_room;
  logic            player_won;
  logic [RM_W-1:0] room_idx;

  room_loader dut (
    .clk(clk), .reset(reset), .game_state(game_state), .exit_reached(exit_reached),
    .rom_addr(rom_addr), .rom_data(rom_data), .obj_we(obj_we), .obj_addr(obj_addr),
    .obj_wdata(obj_wdata), .done_init(done_init), .player_change_room(player_change_room),
    .player_won(player_won), .room_idx(room_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Room ROM: one cycle read latency.
  logic [15:0] rom [0:NR*K-1];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Write monitor.
  typedef struct {int cyc; int addr; int data;} wr_t;
  wr_t wq[$];
  int  cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!reset && obj_we) wq.push_back('{cyc, int'(obj_addr), int'(obj_wdata)});

  // Reference model of room progression.
  int m_room;
  bit m_pending;
  bit m_won;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_gs(input logic [3:0] g);
    if (g == GS_INIT && game_state != GS_INIT && m_pending) begin
      m_room++;
      m_pending = 1'b0;
    end
    game_state = g;
  endtask

  function automatic int exp_data(input int room, input int slot);
    return (slot < K) ? int'(rom[room*K + slot]) : 0;
  endfunction

  // Wait for done_init after INIT has been applied, then check the write stream.
  task automatic wait_load(input string tag);
    int n;
    for (n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done_init) break;
    end
    chk({tag, "_latency"}, n, 16);
    chk({tag, "_nwrites"}, wq.size(), T);
    for (int i = 0; i < wq.size() && i < T; i++) begin
      chk({tag, "_addr"}, wq[i].addr, i);
      chk({tag, "_data"}, wq[i].data, exp_data(m_room, i));
      chk({tag, "_nogap"}, wq[i].cyc - wq[0].cyc, i);
    end
    chk({tag, "_room"}, room_idx, m_room);
    chk({tag, "_romaddr"}, rom_addr, m_room*K + K - 1);
    $display("load %s: room %0d, %0d writes, done after %0d cycles", tag, room_idx, wq.size(), n);
  endtask

  task automatic do_load(input string tag);
    set_gs(GS_OVER);
    tick(2);
    wq.delete();
    set_gs(GS_INIT);
    wait_load(tag);
    set_gs(GS_PROG);
    tick(1);
    chk({tag, "_done_drop"}, done_init, 0);
  endtask

  task automatic do_exit(input logic [3:0] g, input int hold);
    int pulses;
    bit exp_pulse;
    pulses    = 0;
    exp_pulse = 1'b0;
    set_gs(g);
    exit_reached = 1'b0;
    tick(2);
    if (g == GS_PROG) begin
      if (m_room == NR-1) m_won = 1'b1;
      else if (!m_pending) begin
        exp_pulse = 1'b1;
        m_pending = 1'b1;
      end
    end
    exit_reached = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick(1);
      if (player_change_room) pulses++;
    end
    exit_reached = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      if (player_change_room) pulses++;
    end
    chk("exit_pulses", pulses, 32'(exp_pulse));
    chk("exit_won", player_won, m_won);
    chk("exit_room", room_idx, m_room);
    $display("exit gs=%b hold=%0d: pulses=%0d won=%0d room=%0d", g, hold, pulses, player_won, room_idx);
  endtask

  task automatic do_abort();
    int n;
    bit any_done;
    any_done = 1'b0;
    set_gs(GS_OVER);
    tick(2);
    wq.delete();
    set_gs(GS_INIT);
    for (n = 0; n < 40; n++) begin
      tick(1);
      if (obj_we && obj_addr == 2) break;
    end
    chk("abort_reach", n < 40, 1);
    set_gs(GS_OVER);
    tick(1);
    chk("abort_we", obj_we, 0);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (done_init) any_done = 1'b1;
    end
    chk("abort_nwrites", wq.size(), 3);
    chk("abort_done", any_done, 0);
    chk("abort_room", room_idx, m_room);
    $display("abort: %0d writes before abort, room %0d", wq.size(), room_idx);
  endtask

  initial begin
    int r;
    int n;
    for (int a = 0; a < NR*K; a++)
      rom[a] = (a < K) ? 16'(16'h1000 + a) : 16'($urandom);
    m_room = 0; m_pending = 0; m_won = 0;
    reset = 1'b1;
    game_state = GS_OVER;
    exit_reached = 1'b0;
    tick(3);
    chk("reset_outputs", {rom_addr, obj_we, obj_addr, obj_wdata, done_init,
                          player_change_room, player_won, room_idx}, 0);
    reset = 1'b0;
    tick(1);

    // Room 0 load.
    do_load("room0");

    // Long held exit: single pulse; a second edge before INIT gives no pulse.
    do_exit(GS_PROG, 20);
    do_exit(GS_PROG, 5);
    do_load("room1");

    // Exits outside PROGRESSING are ignored.
    do_exit(GS_INIT, 4);
    do_exit(GS_OVER, 3);
    do_load("room1_again");

    do_abort();

    // Randomized mix.
    for (int it = 0; it < 16; it++) begin
      r = $urandom_range(0, 3);
      case (r)
        0, 1: do_exit(GS_PROG, $urandom_range(1, 20));
        2: begin
          n = $urandom_range(0, 2);
          do_exit(n == 0 ? GS_INIT : (n == 1 ? GS_OVER : GS_WIN), $urandom_range(1, 8));
        end
        default: do_load("rand");
      endcase
    end

    // Reach the last room and win.
    while (m_room < NR-1) begin
      do_exit(GS_PROG, 2);
      do_load("advance");
    end
    do_exit(GS_PROG, 3);
    set_gs(GS_WIN);
    tick(3);
    chk("won_in_win", player_won, 1);
    set_gs(GS_END);
    tick(3);
    chk("won_in_end", player_won, 1);
    chk("room_no_wrap", room_idx, NR-1);
    do_exit(GS_PROG, 2);
    do_load("last_room");

    // Reset in the middle of CLEAR, then reload room 0.
    set_gs(GS_OVER);
    tick(2);
    wq.delete();
    set_gs(GS_INIT);
    for (n = 0; n < 40; n++) begin
      tick(1);
      if (obj_we && obj_addr == K + 2) break;
    end
    chk("clear_reach", n < 40, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset", {rom_addr, obj_we, obj_addr, obj_wdata, done_init,
                        player_change_room, player_won, room_idx}, 0);
    m_room = 0; m_pending = 0; m_won = 0;
    tick(2);
    wq.delete();
    reset = 1'b0;
    wait_load("reset_reload");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
